// File: rtl/serial_slave_port.sv
// Bit-serial bus slave endpoint: shifts in mode/address/write-data, strobes local storage, shifts read data back.
// Optional frame parity check enabled by defining SERIAL_SLAVE_PARITY_EN.
module serial_slave_port #(
  parameter int ADDR_WIDTH = 12,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  m_valid,
  input  logic                  m_wdata,
  output logic                  s_ready,
  output logic                  s_valid,
  output logic                  s_rdata,
  input  logic                  m_ready,
  output logic                  s_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  output logic                  mem_wen,
  output logic                  mem_ren,
  input  logic [DATA_WIDTH-1:0] mem_rdata,
  input  logic                  mem_rvalid
);

  localparam int MAX_W = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
  localparam int CW    = $clog2(MAX_W) + 1;
  localparam logic [CW-1:0] ADDR_LAST = CW'(ADDR_WIDTH - 1);
  localparam logic [CW-1:0] DATA_LAST = CW'(DATA_WIDTH - 1);

  typedef enum logic [2:0] {
    IDLE,
    ADDR,
    WDATA,
`ifdef SERIAL_SLAVE_PARITY_EN
    PAR,
`endif
    WRITE,
    RREQ,
    RWAIT,
    RSEND
  } state_t;

  state_t                state;
  logic [CW-1:0]         cnt;
  logic                  mode;
  logic [ADDR_WIDTH-1:0] addr_sr;
  logic [DATA_WIDTH-1:0] wdata_sr;
  logic [DATA_WIDTH-1:0] rdata_sr;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] wdata_next;

  // Shift registers fill LSB first: new bit enters at the top.
  assign addr_next  = {m_wdata, addr_sr[ADDR_WIDTH-1:1]};
  assign wdata_next = {m_wdata, wdata_sr[DATA_WIDTH-1:1]};

`ifdef SERIAL_SLAVE_PARITY_EN
  logic parity_acc;
`else
  assign s_err = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      mode      <= 1'b0;
      addr_sr   <= '0;
      wdata_sr  <= '0;
      rdata_sr  <= '0;
      s_ready   <= 1'b1;
      s_valid   <= 1'b0;
      s_rdata   <= 1'b0;
      mem_wen   <= 1'b0;
      mem_ren   <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
`ifdef SERIAL_SLAVE_PARITY_EN
      parity_acc <= 1'b0;
      s_err      <= 1'b0;
`endif
    end else begin
      mem_wen <= 1'b0;
      mem_ren <= 1'b0;
`ifdef SERIAL_SLAVE_PARITY_EN
      s_err   <= 1'b0;
`endif
      case (state)
        IDLE: if (m_valid) begin
          mode    <= m_wdata;
          cnt     <= '0;
          s_ready <= 1'b0;
          state   <= ADDR;
`ifdef SERIAL_SLAVE_PARITY_EN
          parity_acc <= m_wdata;
`endif
        end
        ADDR: if (m_valid) begin
          addr_sr <= addr_next;
          cnt     <= cnt + 1'b1;
`ifdef SERIAL_SLAVE_PARITY_EN
          parity_acc <= parity_acc ^ m_wdata;
`endif
          if (cnt == ADDR_LAST) begin
            cnt <= '0;
`ifdef SERIAL_SLAVE_PARITY_EN
            state <= mode ? WDATA : PAR;
`else
            if (mode) begin
              state <= WDATA;
            end else begin
              state    <= RREQ;
              mem_ren  <= 1'b1;
              mem_addr <= addr_next;
            end
`endif
          end
        end
        WDATA: if (m_valid) begin
          wdata_sr <= wdata_next;
          cnt      <= cnt + 1'b1;
`ifdef SERIAL_SLAVE_PARITY_EN
          parity_acc <= parity_acc ^ m_wdata;
`endif
          if (cnt == DATA_LAST) begin
            cnt <= '0;
`ifdef SERIAL_SLAVE_PARITY_EN
            state <= PAR;
`else
            state     <= WRITE;
            mem_wen   <= 1'b1;
            mem_addr  <= addr_sr;
            mem_wdata <= wdata_next;
`endif
          end
        end
`ifdef SERIAL_SLAVE_PARITY_EN
        // Even parity: the accumulated XOR of the frame must equal the parity bit.
        PAR: if (m_valid) begin
          cnt <= '0;
          if (parity_acc != m_wdata) begin
            state   <= IDLE;
            s_err   <= 1'b1;
            s_ready <= 1'b1;
          end else if (mode) begin
            state     <= WRITE;
            mem_wen   <= 1'b1;
            mem_addr  <= addr_sr;
            mem_wdata <= wdata_sr;
          end else begin
            state    <= RREQ;
            mem_ren  <= 1'b1;
            mem_addr <= addr_sr;
          end
        end
`endif
        WRITE: begin
          state   <= IDLE;
          cnt     <= '0;
          s_ready <= 1'b1;
        end
        RREQ, RWAIT: begin
          cnt <= '0;
          if (mem_rvalid) begin
            rdata_sr <= mem_rdata;
            s_rdata  <= mem_rdata[0];
            s_valid  <= 1'b1;
            state    <= RSEND;
          end else begin
            state <= RWAIT;
          end
        end
        RSEND: if (m_ready) begin
          cnt      <= cnt + 1'b1;
          rdata_sr <= rdata_sr >> 1;
          s_rdata  <= rdata_sr[1];
          if (cnt == DATA_LAST) begin
            cnt     <= '0;
            s_valid <= 1'b0;
            s_ready <= 1'b1;
            state   <= IDLE;
          end
        end
        default: begin
          state   <= IDLE;
          cnt     <= '0;
          s_ready <= 1'b1;
          s_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_serial_slave_port.sv
// Scoreboard bench for serial_slave_port: stimulus pushes expected memory strobes,
// read words and error pulses; a negedge monitor pops and compares them.
module tb_serial_slave_port;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        m_valid = 1'b0;
  logic        m_wdata = 1'b0;
  logic        s_ready, s_valid, s_rdata, s_err;
  logic        m_ready = 1'b1;
  logic [11:0] mem_addr;
  logic [7:0]  mem_wdata;
  logic        mem_wen, mem_ren;
  logic [7:0]  mem_rdata = 8'h00;
  logic        mem_rvalid = 1'b0;

  int tests = 0;
  int fails = 0;

  // kind: 0 write strobe, 1 read strobe, 2 returned read word, 3 error pulse
  typedef struct {
    int          kind;
    logic [11:0] addr;
    logic [7:0]  data;
  } exp_t;
  exp_t exp_q[$];

  int         rd_delay = 0;
  logic [7:0] rd_data  = 8'h00;
  logic       toggle_ready = 1'b0;

  always #5 clk = ~clk;

  serial_slave_port #(.ADDR_WIDTH(12), .DATA_WIDTH(8)) dut (
    .clk(clk), .rst(rst), .m_valid(m_valid), .m_wdata(m_wdata),
    .s_ready(s_ready), .s_valid(s_valid), .s_rdata(s_rdata), .m_ready(m_ready),
    .s_err(s_err), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_wen(mem_wen), .mem_ren(mem_ren), .mem_rdata(mem_rdata), .mem_rvalid(mem_rvalid)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    tests++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, req);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Storage model: answers each read strobe after rd_delay cycles (0 = same cycle).
  initial begin
    forever begin
      @(negedge clk);
      if (mem_ren) begin
        if (rd_delay > 0) repeat (rd_delay) @(negedge clk);
        mem_rdata  = rd_data;
        mem_rvalid = 1'b1;
        @(negedge clk);
        mem_rvalid = 1'b0;
      end
    end
  end

  initial begin
    forever begin
      @(posedge clk);
      #1;
      m_ready = toggle_ready ? ~m_ready : 1'b1;
    end
  end

  // Monitor
  logic [7:0] rx_word = 8'h00;
  int         rx_cnt  = 0;
  logic       hold_pending = 1'b0;
  logic       hold_bit = 1'b0;
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst) begin
        if (hold_pending && s_valid) chk("rsend_bit_held", s_rdata, hold_bit);
        hold_pending = 1'b0;
        if (mem_wen) begin
          if (exp_q.size() == 0) chk("unexpected_mem_wen", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("wen_kind", e.kind, 0);
            chk("wen_addr", mem_addr, e.addr);
            chk("wen_data", mem_wdata, e.data);
          end
        end
        if (mem_ren) begin
          if (exp_q.size() == 0) chk("unexpected_mem_ren", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("ren_kind", e.kind, 1);
            chk("ren_addr", mem_addr, e.addr);
          end
        end
        if (s_err) begin
          if (exp_q.size() == 0) chk("unexpected_s_err", 1, 0);
          else begin
            e = exp_q.pop_front();
            chk("err_kind", e.kind, 3);
          end
        end
        if (s_valid && !m_ready) begin
          hold_pending = 1'b1;
          hold_bit     = s_rdata;
        end
        if (s_valid && m_ready) begin
          rx_word = {s_rdata, rx_word[7:1]};
          rx_cnt++;
          if (rx_cnt == 8) begin
            rx_cnt = 0;
            if (exp_q.size() == 0) chk("unexpected_read_word", 1, 0);
            else begin
              e = exp_q.pop_front();
              chk("rword_kind", e.kind, 2);
              chk("rword_data", rx_word, e.data);
            end
          end
        end
      end
    end
  end

`ifdef SERIAL_SLAVE_PARITY_EN
  logic bad_par = 1'b0;
`endif

  task automatic send_frame(input logic mode, input logic [11:0] addr, input logic [7:0] data,
                            input int stall_every);
    logic bits[$];
    bits.push_back(mode);
    for (int i = 0; i < 12; i++) bits.push_back(addr[i]);
    if (mode) for (int i = 0; i < 8; i++) bits.push_back(data[i]);
`ifdef SERIAL_SLAVE_PARITY_EN
    bits.push_back((mode ? ^{mode, addr, data} : ^{mode, addr}) ^ bad_par);
`endif
    for (int i = 0; i < bits.size(); i++) begin
      m_valid = 1'b1;
      m_wdata = bits[i];
      @(posedge clk);
      #1;
      if (stall_every > 0 && (i % stall_every) == stall_every - 1 && i != bits.size() - 1) begin
        m_valid = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
      end
    end
    m_valid = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (!s_ready && n < 200) begin
      @(posedge clk);
      #1;
      n++;
    end
    if (!s_ready) chk({name, "_idle_timeout"}, 0, 1);
  endtask

  task automatic push(input int kind, input logic [11:0] a, input logic [7:0] d);
    exp_t e;
    e.kind = kind; e.addr = a; e.data = d;
    exp_q.push_back(e);
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_s_ready", s_ready, 1);
    chk("reset_s_valid", s_valid, 0);
    chk("reset_mem_wen", mem_wen, 0);
    chk("reset_mem_addr", mem_addr, 0);
    rst = 1'b0;
    @(posedge clk); #1;

    // Write without stalls; strobe must appear the cycle right after the last bit
    push(0, 12'h0A8, 8'h5C);
    send_frame(1'b1, 12'h0A8, 8'h5C, 0);
    chk("write_latency_wen", mem_wen, 1);
    @(posedge clk); #1;
    chk("write_wen_one_cycle", mem_wen, 0);
    chk("write_s_ready_after", s_ready, 1);

    // Read with 3-cycle storage latency
    rd_delay = 3; rd_data = 8'hA5;
    push(1, 12'h0A8, 8'h00); push(2, 12'h000, 8'hA5);
    send_frame(1'b0, 12'h0A8, 8'h00, 0);
    wait_idle("read_wait");
    chk("read_s_valid_after", s_valid, 0);

    // Write with stalls after every third bit
    push(0, 12'hFFF, 8'h00);
    send_frame(1'b1, 12'hFFF, 8'h00, 3);
    wait_idle("write_stall");

    // Read with m_ready toggling
    rd_delay = 1; rd_data = 8'h3C; toggle_ready = 1'b1;
    push(1, 12'h123, 8'h00); push(2, 12'h000, 8'h3C);
    send_frame(1'b0, 12'h123, 8'h00, 0);
    wait_idle("read_toggle");
    toggle_ready = 1'b0;
    @(posedge clk); #1;

    // Reset after mode + 6 address bits of a write
    for (int i = 0; i < 7; i++) begin
      m_valid = 1'b1; m_wdata = 1'b1;
      @(posedge clk); #1;
    end
    m_valid = 1'b0;
    chk("midframe_s_ready_low", s_ready, 0);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid_s_ready", s_ready, 1);
    chk("rst_mid_mem_wen", mem_wen, 0);
    chk("rst_mid_mem_addr", mem_addr, 0);
    chk("rst_mid_mem_wdata", mem_wdata, 0);
    rst = 1'b0;
    @(posedge clk); #1;
    push(0, 12'h001, 8'h81);
    send_frame(1'b1, 12'h001, 8'h81, 0);
    wait_idle("write_after_rst");

    // Immediate rvalid in the read-strobe cycle
    rd_delay = 0; rd_data = 8'hFF;
    push(1, 12'h7FF, 8'h00); push(2, 12'h000, 8'hFF);
    send_frame(1'b0, 12'h7FF, 8'h00, 0);
    chk("imm_ren", mem_ren, 1);
    @(posedge clk); #1;
    chk("imm_rsend_next_cycle", s_valid, 1);
    wait_idle("read_imm");

`ifdef SERIAL_SLAVE_PARITY_EN
    bad_par = 1'b1;
    push(3, 12'h000, 8'h00);
    send_frame(1'b1, 12'h0A8, 8'h5C, 0);
    chk("par_bad_s_err", s_err, 1);
    chk("par_bad_no_wen", mem_wen, 0);
    @(posedge clk); #1;
    chk("par_bad_s_err_one_cycle", s_err, 0);
    bad_par = 1'b0;
    wait_idle("par_bad");
    push(0, 12'h0A8, 8'h5C);
    send_frame(1'b1, 12'h0A8, 8'h5C, 0);
    chk("par_good_wen", mem_wen, 1);
    chk("par_good_no_err", s_err, 0);
    wait_idle("par_good");
`endif

    repeat (10) @(posedge clk);
    #1;
    chk("scoreboard_drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/serial_slave_port.md
Name: serial_slave_port

Overview:
Slave-side endpoint of the bit-serial system bus. It accepts mode, address and write-data bits shifted in by a master through the interconnect. It issues a single-cycle write or read to a local memory/register array. For reads it shifts the returned word back to the master. It sits between the bus interconnect (slave side) and one slave's storage.

Parameters:
ADDR_WIDTH, 12, local address bits carried serially (slave-select bits are already stripped by the interconnect)
DATA_WIDTH, 8, data word width

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset; synchronous, active-high
m_valid  in  1  master bit valid; qualifies m_wdata
m_wdata  in  1  serial bit from master: mode, then address, then write data
s_ready  out  1  slave idle and able to start a transaction
s_valid  out  1  read-data bit valid on s_rdata
s_rdata  out  1  serial read-data bit to master
m_ready  in  1  master accepts the current s_rdata bit
s_err  out  1  one-cycle pulse on frame error (see Optional Feature)
mem_addr  out  ADDR_WIDTH  storage address
mem_wdata  out  DATA_WIDTH  storage write data
mem_wen  out  1  one-cycle write strobe
mem_ren  out  1  one-cycle read strobe
mem_rdata  in  DATA_WIDTH  storage read data
mem_rvalid  in  1  mem_rdata valid

Behaviour:
- Reset (rst=1 at a clock edge):
  - State goes to IDLE; bit counter and shift registers are cleared.
  - s_ready=1; s_valid, s_rdata, s_err, mem_wen and mem_ren are 0; mem_addr and mem_wdata are 0.
  - Reset overrides any in-flight transaction. A partial write is discarded and no strobe is issued.
- States: IDLE, ADDR, WDATA, [PAR], WRITE, RREQ, RWAIT, RSEND.
- A bit is accepted only in a cycle where m_valid=1 while in IDLE, ADDR, WDATA or PAR.
- m_valid=0 mid-frame stalls the frame: the bit counter holds and there is no timeout.
- IDLE:
  - s_ready=1.
  - An accepted bit is the mode bit: 1=write, 0=read. It is latched and the state goes to ADDR.
  - s_ready=0 from the next cycle until the state returns to IDLE.
- ADDR: accepts ADDR_WIDTH bits, LSB first, into the address shift register. After the last bit:
  - write → WDATA;
  - read → RREQ;
  - → PAR instead if PARITY_EN is defined.
- WDATA: accepts DATA_WIDTH bits, LSB first. After the last bit → WRITE (or PAR).
- WRITE:
  - mem_wen=1 for exactly one cycle, with mem_addr and mem_wdata stable.
  - Next state IDLE.
  - Latency: mem_wen is high in the cycle immediately after the last accepted bit.
- RREQ:
  - mem_ren=1 for exactly one cycle, with mem_addr stable.
  - If mem_rvalid=1 in this same cycle, mem_rdata is latched and the next state is RSEND; otherwise RWAIT.
- RWAIT: waits indefinitely for mem_rvalid=1, then latches mem_rdata → RSEND.
- RSEND:
  - s_valid=1 and s_rdata=current bit, LSB first.
  - The bit advances on s_valid&&m_ready.
  - After DATA_WIDTH handshakes → IDLE; s_valid=0 in the following cycle.
  - m_valid is ignored in RSEND, RWAIT, RREQ and WRITE.
- mem_addr and mem_wdata hold their last value outside strobe cycles.
- Counter: $clog2(max(ADDR_WIDTH,DATA_WIDTH))+1 bits; cleared on every state change.

Optional Feature:
Macro: SERIAL_SLAVE_PARITY_EN.
- Defined:
  - After the final address bit (read) or final data bit (write), the master sends one more bit, accepted in state PAR.
  - That bit is even parity over mode, address and (for writes) data.
  - Match → WRITE or RREQ.
  - Mismatch → IDLE with no mem strobe, and s_err=1 for one cycle, in the cycle after the parity bit.
- Not defined: PAR state absent, frames carry no parity bit, s_err tied 0.

Test Plan:
- Write, no stalls: mode=1, addr=0x0A8, data=0x5C, m_valid held high, 21 bits → mem_wen high exactly one cycle after the 21st bit; mem_addr=0x0A8, mem_wdata=0x5C; s_ready=1 the cycle after.
- Read with wait states: mode=0, addr=0x0A8; memory returns 0xA5 with mem_rvalid 3 cycles after mem_ren; m_ready=1 → s_rdata bits 1,0,1,0,0,1,0,1 on 8 consecutive s_valid cycles, then s_valid=0 and s_ready=1.
- Stalls:
  - Write addr=0xFFF, data=0x00, with m_valid=0 for 2 cycles after every 3rd bit → mem_wen once, mem_addr=0xFFF, mem_wdata=0x00.
  - Read with m_ready toggling 1/0 → each bit held until handshake, 0x3C reconstructed exactly.
- Reset mid-transaction: rst=1 after 6 address bits of a write → no mem_wen, all outputs at reset values; a following full write of 0x001/0x81 completes correctly.
- Immediate rvalid: mem_rvalid=1 in the RREQ cycle with 0xFF → RSEND starts the next cycle, 8 ones returned.
- Parity (macro defined):
  - Write 0x0A8/0x5C with wrong parity bit → no mem_wen, s_err pulse of 1 cycle.
  - Same frame with correct parity → mem_wen, s_err stays 0.
